mul_execute_unit: RTL and testbench

//   EX-stage iterative multiplier, directly downstream of the ALU control decoder.

---
 rtl/mul_execute_unit.sv | 112 +++++++++++
 tb/tb_mul_execute_unit.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mul_execute_unit.sv
// EX-stage iterative shift-add multiplier returning the low XLEN bits of A*B.
// Holds the pipeline through stall_o while the product is formed over XLEN/STEP cycles.
module mul_execute_unit #(
  parameter int         XLEN   = 32,
  parameter int         STEP   = 1,
  parameter logic [3:0] MUL_OP = 4'b1110
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_i,
  input  logic [3:0]      ALU_Operation_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] A_i,
  input  logic [XLEN-1:0] B_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int N     = XLEN / STEP;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, state_next;
  logic [XLEN-1:0]   acc, mcand, mplier;
  logic [XLEN-1:0]   acc_step, mcand_step, mplier_step;
  logic [CNT_W-1:0]  cnt;
  logic              start;
  logic              last_step;

  assign start     = valid_i && (ALU_Operation_i == MUL_OP) && !flush_i;
  assign last_step = (cnt == LAST_CNT);

  // Retire STEP multiplier bits, LSB first, in one cycle.
  // NOTE: blocking assignments chain the partial results through the loop within the
  // cycle; every variable gets a default first so no latch is inferred.
  always_comb begin
    acc_step    = acc;
    mcand_step  = mcand;
    mplier_step = mplier;
    for (int i = 0; i < STEP; i++) begin
      if (mplier_step[0]) acc_step = acc_step + mcand_step;
      mcand_step  = mcand_step << 1;
      mplier_step = mplier_step >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = BUSY;
      BUSY: begin
        if (flush_i)        state_next = IDLE;
        else if (last_step) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    stall_o = 1'b0;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state)
      IDLE:    stall_o = start;
      BUSY: begin
        stall_o = 1'b1;
        busy_o  = 1'b1;
      end
      DONE:    done_o = 1'b1;
      default: ;
    endcase
  end

  // result_o is loaded on the edge into DONE, so it is already valid while done_o is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
      result_o <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          mcand  <= A_i;
          mplier <= B_i;
          acc    <= '0;
          cnt    <= '0;
        end
        BUSY: begin
          acc    <= acc_step;
          mcand  <= mcand_step;
          mplier <= mplier_step;
          cnt    <= cnt + CNT_W'(1);
          if (last_step && !flush_i) result_o <= acc_step;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_execute_unit.sv
// Directed bench for mul_execute_unit: STEP=1 instance for most cases, STEP=4 for latency.
// Inputs change #1 after the rising edge; outputs are sampled on the falling edge.
module tb_mul_execute_unit;

  localparam logic [3:0] MUL = 4'b1110;

  logic        clk = 1'b0;
  logic        reset, valid, valid4, flush;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        stall, busy, done, stall4, busy4, done4;
  logic [31:0] result, result4;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int last_done_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mul_execute_unit u_dut (
    .clk(clk), .reset(reset), .valid_i(valid), .ALU_Operation_i(op), .flush_i(flush),
    .A_i(a), .B_i(b), .stall_o(stall), .busy_o(busy), .done_o(done), .result_o(result)
  );

  mul_execute_unit #(.STEP(4)) u_dut4 (
    .clk(clk), .reset(reset), .valid_i(valid4), .ALU_Operation_i(op), .flush_i(flush),
    .A_i(a), .B_i(b), .stall_o(stall4), .busy_o(busy4), .done_o(done4), .result_o(result4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Launch one MUL and hold it until done_o; n is XLEN/STEP of the chosen instance.
  task automatic do_mul(input bit use4, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] expv, input int n, input string tag);
    int stalls = 0;
    int done_at = 0;
    logic [31:0] res = '0;
    a = av; b = bv; op = MUL; flush = 1'b0;
    if (use4) valid4 = 1'b1; else valid = 1'b1;
    for (int c = 1; c <= n + 6; c++) begin
      @(negedge clk);
      if (use4 ? stall4 : stall) stalls++;
      if (use4 ? done4 : done) begin
        done_at = c;
        res = use4 ? result4 : result;
        last_done_cyc = cyc;
        break;
      end
      next_cycle();
    end
    next_cycle();
    valid = 1'b0; valid4 = 1'b0;
    check({tag, " stall cycles"}, stalls, n + 1);
    check({tag, " done cycle"}, done_at, n + 2);
    check({tag, " result"}, res, expv);
  endtask

  initial begin
    int d1;
    int seen;
    reset = 1'b1; valid = 1'b0; valid4 = 1'b0; flush = 1'b0; op = 4'b0000; a = '0; b = '0;
    repeat (2) next_cycle();
    @(negedge clk);
    check("reset stall", stall, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset result", result, 0);
    next_cycle();
    reset = 1'b0;

    // Non-MUL op with valid, then MUL without valid: unit must stay idle.
    op = 4'b0000; valid = 1'b1; a = 32'd7; b = 32'd6;
    seen = 0;
    repeat (3) begin @(negedge clk); if (stall || busy || done) seen++; next_cycle(); end
    check("non-mul idle", seen, 0);
    op = MUL; valid = 1'b0;
    seen = 0;
    repeat (3) begin @(negedge clk); if (stall || busy || done) seen++; next_cycle(); end
    check("invalid mul idle", seen, 0);

    // MUL request with flush in IDLE: no start, no stall.
    valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    check("idle flush stall", stall, 0);
    next_cycle();
    valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("idle flush busy", busy, 0);
    next_cycle();

    do_mul(1'b0, 32'd7, 32'd6, 32'd42, 32, "7*6");
    @(negedge clk);
    check("done one-shot", done, 0);
    check("result holds", result, 32'd42);
    next_cycle();

    do_mul(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32, "ff*ff");
    do_mul(1'b0, 32'h8000_0000, 32'd2, 32'h0000_0000, 32, "wrap");

    // Back-to-back: the second MUL is presented in the IDLE cycle right after DONE.
    do_mul(1'b0, 32'd3, 32'd5, 32'd15, 32, "b2b 3*5");
    d1 = last_done_cyc;
    do_mul(1'b0, 32'd9, 32'd9, 32'd81, 32, "b2b 9*9");
    check("b2b done spacing", last_done_cyc - d1, 34);

    // Flush during BUSY cycle 10.
    a = 32'd100; b = 32'd3; op = MUL; valid = 1'b1;
    repeat (10) next_cycle();
    flush = 1'b1;
    @(negedge clk);
    check("flush cycle busy", busy, 1);
    next_cycle();
    flush = 1'b0; valid = 1'b0;
    @(negedge clk);
    check("after flush stall", stall, 0);
    check("after flush busy", busy, 0);
    check("after flush result", result, 32'd81);
    seen = 0;
    repeat (40) begin if (done) seen++; next_cycle(); @(negedge clk); end
    check("flush no done", seen, 0);
    next_cycle();

    // Reset during BUSY cycle 5, then a clean multiply.
    a = 32'd11; b = 32'd13; op = MUL; valid = 1'b1;
    repeat (5) next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0; valid = 1'b0;
    @(negedge clk);
    check("mid reset stall", stall, 0);
    check("mid reset busy", busy, 0);
    check("mid reset done", done, 0);
    check("mid reset result", result, 0);
    next_cycle();
    do_mul(1'b0, 32'd11, 32'd13, 32'd143, 32, "after reset 11*13");

    // STEP=4 instance: 9 stall cycles, done in cycle 10.
    do_mul(1'b1, 32'd3, 32'd5, 32'd15, 8, "step4 3*5");
    d1 = last_done_cyc;
    do_mul(1'b1, 32'd9, 32'd9, 32'd81, 8, "step4 9*9");
    check("step4 done spacing", last_done_cyc - d1, 10);
    check("step1 unit idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
